// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit0=a .. bit6=g),
// capture/frame state types and the pattern-to-nibble decode function.
package seg7_pkg;

  typedef logic [6:0] seg7_pat_t;

  localparam seg7_pat_t SEG7_PAT_0     = 7'b1000000;
  localparam seg7_pat_t SEG7_PAT_1     = 7'b1111001;
  localparam seg7_pat_t SEG7_PAT_2     = 7'b0100100;
  localparam seg7_pat_t SEG7_PAT_3     = 7'b0110000;
  localparam seg7_pat_t SEG7_PAT_4     = 7'b0011001;
  localparam seg7_pat_t SEG7_PAT_5     = 7'b0010010;
  localparam seg7_pat_t SEG7_PAT_6     = 7'b0000010;
  localparam seg7_pat_t SEG7_PAT_7     = 7'b1111000;
  localparam seg7_pat_t SEG7_PAT_8     = 7'b0000000;
  localparam seg7_pat_t SEG7_PAT_9     = 7'b0010000;
  localparam seg7_pat_t SEG7_PAT_A     = 7'b0001000;
  localparam seg7_pat_t SEG7_PAT_B     = 7'b0000011;
  localparam seg7_pat_t SEG7_PAT_C     = 7'b1000110;
  localparam seg7_pat_t SEG7_PAT_D     = 7'b0100001;
  localparam seg7_pat_t SEG7_PAT_E     = 7'b0000110;
  localparam seg7_pat_t SEG7_PAT_F     = 7'b0001110;
  localparam seg7_pat_t SEG7_PAT_BLANK = 7'b1111111;

  typedef enum logic {CAP_WAIT, CAP_HOLD} cap_state_t;
  typedef enum logic {FR_COLLECT, FR_PRESENT} fr_state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  // Inverse of the driver table; blank is legal with a zero nibble.
  function automatic seg7_dec_t seg7_decode(input seg7_pat_t pat);
    seg7_dec_t r;
    r.legal  = 1'b1;
    r.blank  = 1'b0;
    r.nibble = 4'h0;
    case (pat)
      SEG7_PAT_0:     r.nibble = 4'h0;
      SEG7_PAT_1:     r.nibble = 4'h1;
      SEG7_PAT_2:     r.nibble = 4'h2;
      SEG7_PAT_3:     r.nibble = 4'h3;
      SEG7_PAT_4:     r.nibble = 4'h4;
      SEG7_PAT_5:     r.nibble = 4'h5;
      SEG7_PAT_6:     r.nibble = 4'h6;
      SEG7_PAT_7:     r.nibble = 4'h7;
      SEG7_PAT_8:     r.nibble = 4'h8;
      SEG7_PAT_9:     r.nibble = 4'h9;
      SEG7_PAT_A:     r.nibble = 4'hA;
      SEG7_PAT_B:     r.nibble = 4'hB;
      SEG7_PAT_C:     r.nibble = 4'hC;
      SEG7_PAT_D:     r.nibble = 4'hD;
      SEG7_PAT_E:     r.nibble = 4'hE;
      SEG7_PAT_F:     r.nibble = 4'hF;
      SEG7_PAT_BLANK: r.blank  = 1'b1;
      default:        r.legal  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern decoder (wrapper around seg7_decode).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg7_pat_t  pat,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  seg7_dec_t dec;

  // Decode the active-low segment pattern into legal/blank/nibble.
  always_comb begin
    dec    = seg7_decode(pat);
    legal  = dec.legal;
    blank  = dec.blank;
    nibble = dec.nibble;
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed 7-segment bus reader: waits for each digit pattern to hold
// stable, decodes it, and presents complete frames on valid/ready.
// Optional SEG7_INPUT_SYNC_EN adds a 2-flop synchronizer on seg_n/dig_sel_n.
//
// state      | meaning
// CAP_WAIT   | counting consecutive identical eligible samples
// CAP_HOLD   | pattern captured; waiting for the sample to change
// FR_COLLECT | gathering captures until every digit has one
// FR_PRESENT | frame on outputs, frozen until accepted
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    err_pattern
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SW    = NUM_DIGITS + 7;

  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] dig_s;

`ifdef SEG7_INPUT_SYNC_EN
  logic [6:0]            seg_meta_q, seg_sync_q;
  logic [NUM_DIGITS-1:0] dig_meta_q, dig_sync_q;

  // Two-flop synchronizer; idles at all ones (nothing lit, no digit enabled).
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      dig_meta_q <= '1;
      dig_sync_q <= '1;
    end else begin
      seg_meta_q <= seg_n;
      seg_sync_q <= seg_meta_q;
      dig_meta_q <= dig_sel_n;
      dig_sync_q <= dig_meta_q;
    end
  end

  assign seg_s = seg_sync_q;
  assign dig_s = dig_sync_q;
`else
  assign seg_s = seg_n;
  assign dig_s = dig_sel_n;
`endif

  logic [SW-1:0]           sample;
  logic                    eligible;
  logic                    dec_legal, dec_blank;
  logic [3:0]              dec_nibble;

  cap_state_t              cap_state_q, cap_state_d;
  fr_state_t               fr_state_q, fr_state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]           prev_q, prev_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] live_data_q, live_data_d;
  logic [NUM_DIGITS-1:0]   live_blank_q, live_blank_d;
  logic [4*NUM_DIGITS-1:0] frame_data_q, frame_data_d;
  logic [NUM_DIGITS-1:0]   frame_blank_q, frame_blank_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    err_q, err_d;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_bits;
  logic [NUM_DIGITS-1:0]   mask_next;

  assign sample   = {dig_s, seg_s};
  assign eligible = $onehot(~dig_s);

  seg7_pattern_decode u_decode (
    .pat    (seg_s),
    .legal  (dec_legal),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  // Next-state logic for capture FSM, live registers and frame FSM.
  always_comb begin
    cap_state_d   = cap_state_q;
    fr_state_d    = fr_state_q;
    cnt_d         = cnt_q;
    prev_d        = sample;
    mask_d        = mask_q;
    live_data_d   = live_data_q;
    live_blank_d  = live_blank_q;
    frame_data_d  = frame_data_q;
    frame_blank_d = frame_blank_q;
    frame_valid_d = frame_valid_q;
    capture       = 1'b0;

    case (cap_state_q)
      CAP_WAIT: begin
        if (!eligible) begin
          cnt_d = '0;
        end else if (sample == prev_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
            capture     = 1'b1;
            cap_state_d = CAP_HOLD;
          end
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      default: begin
        if (!eligible) begin
          cnt_d       = '0;
          cap_state_d = CAP_WAIT;
        end else if (sample != prev_q) begin
          cnt_d       = CNT_W'(1);
          cap_state_d = CAP_WAIT;
        end
      end
    endcase

    err_d    = capture & ~dec_legal;
    cap_bits = (capture & dec_legal) ? ~dig_s : '0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_bits[i]) begin
        live_data_d[4*i +: 4] = dec_blank ? 4'h0 : dec_nibble;
        live_blank_d[i]       = dec_blank;
      end
    end

    mask_next = mask_q | cap_bits;

    case (fr_state_q)
      FR_COLLECT: begin
        if (&mask_next) begin
          frame_data_d  = live_data_d;
          frame_blank_d = live_blank_d;
          frame_valid_d = 1'b1;
          fr_state_d    = FR_PRESENT;
          // A capture landing when the mask was already full starts the next frame.
          mask_d        = (&mask_q) ? cap_bits : '0;
        end else begin
          mask_d = mask_next;
        end
      end
      default: begin
        mask_d = mask_next;
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          fr_state_d    = FR_COLLECT;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state_q   <= CAP_WAIT;
      fr_state_q    <= FR_COLLECT;
      cnt_q         <= '0;
      prev_q        <= '1;
      mask_q        <= '0;
      live_data_q   <= '0;
      live_blank_q  <= '0;
      frame_data_q  <= '0;
      frame_blank_q <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cap_state_q   <= cap_state_d;
      fr_state_q    <= fr_state_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      mask_q        <= mask_d;
      live_data_q   <= live_data_d;
      live_blank_q  <= live_blank_d;
      frame_data_q  <= frame_data_d;
      frame_blank_q <= frame_blank_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_blank = frame_blank_q;
  assign frame_valid = frame_valid_q;
  assign err_pattern = err_q;

endmodule
